// File: rtl/mux_gate_arbiter.sv
// Round-robin arbiter sharing one bitwise mux-form gate unit between NREQ requesters.
// Latency: grant at T, rsp_valid from T+2; no new grant until the response handshakes.
module mux_gate_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic             win_found;
    logic [ID_W:0]    win_inc;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  id_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Each opcode picks the (a=1, a=0) data pair; every result bit is a 2:1 mux on a[k].
    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    begin x = b;    y = '0;   end
            3'd1:    begin x = '1;   y = b;    end
            3'd2:    begin x = ~b;   y = '1;   end
            3'd3:    begin x = '0;   y = ~b;   end
            3'd4:    begin x = ~b;   y = b;    end
            3'd5:    begin x = b;    y = ~b;   end
            3'd6:    begin x = '1;   y = '0;   end
            default: begin x = '0;   y = '1;   end
        endcase
        for (int k = 0; k < WIDTH; k++) begin
            r[k] = a[k] ? x[k] : y[k];
        end
        return r;
    endfunction

    // Search upward from ptr with wrap-around; the first valid requester wins.
    always_comb begin
        logic [ID_W:0] cand;
        cand      = '0;
        win       = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win       = cand[ID_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    assign win_inc = {1'b0, win} + (ID_W+1)'(1);
    assign ptr_nxt = (win_inc == (ID_W+1)'(NREQ)) ? '0 : win_inc[ID_W-1:0];

    // Gated by rst_n so no grant is visible while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && win_found) begin
            req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_q  <= req_op[3*int'(win) +: 3];
                        a_q   <= req_a[WIDTH*int'(win) +: WIDTH];
                        b_q   <= req_b[WIDTH*int'(win) +: WIDTH];
                        id_q  <= win;
                        ptr   <= ptr_nxt;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= gate_eval(op_q, a_q, b_q);
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mux_gate_arbiter.md
Name: mux_gate_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bitwise mux-based gate unit between NREQ requesters.
- Each requester submits an opcode and two operands over a valid/ready handshake.
- The block grants one request, evaluates the selected gate bit-wise using 2:1 mux form, and returns the result with the winner's ID over a valid/ready response channel.
- Sits between the requester blocks and the shared logic-gate datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(NREQ), width of rsp_id (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i: requester i has a request pending.
- req_ready  output  NREQ  one-hot grant; bit i high means requester i's request is accepted this cycle.
- req_op  input  3*NREQ  opcode for requester i in bits [3i+2:3i].
- req_a  input  WIDTH*NREQ  operand A (mux select) for requester i in slice i.
- req_b  input  WIDTH*NREQ  operand B (mux data) for requester i in slice i.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  gate result.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- busy  output  1  high in EXEC and RESP.

Behaviour:
- Reset: one clock, asynchronous active-low reset, named clk and rst_n. On rst_n low, asynchronously clear:
  - state to IDLE;
  - rsp_valid, rsp_data, rsp_id, busy to 0;
  - req_ready to all 0;
  - round-robin pointer to 0 (requester 0 highest priority).
- Opcodes, evaluated per bit as a ? X : Y:
  - 0 AND: b : 0
  - 1 OR: 1 : b
  - 2 NAND: ~b : 1
  - 3 NOR: 0 : ~b
  - 4 XOR: ~b : b
  - 5 XNOR: b : ~b
  - 6 BUF A: 1 : 0
  - 7 NOT A: 0 : 1
- Implementation: the result is formed as a per-bit mux with select a[k]. No arithmetic; result width is WIDTH.
- State IDLE:
  - req_ready is combinational, the one-hot winner among req_valid, searched from pointer upward with wrap-around.
  - If no req_valid bit is set, req_ready = 0 and the state stays IDLE.
  - On a grant edge: capture op, a, b and the winner index; set pointer = (winner+1) mod NREQ; go to EXEC.
- State EXEC: req_ready = 0. Compute the result into rsp_data, load rsp_id, set rsp_valid = 1, go to RESP.
- State RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable.
  - On rsp_ready = 1: rsp_valid is cleared at the edge and the state goes to IDLE.
  - If rsp_ready stays 0, hold indefinitely.
- Latency: grant at cycle T, rsp_valid high from cycle T+2. Minimum issue interval is 3 cycles (rsp_ready tied high).
- Requester handshake: a requester must hold req_valid and its operands stable until it sees its req_ready bit. Deasserting req_valid before grant withdraws the request, with no side effect.
- Fairness: with all NREQ requesting continuously, grants are 0,1,2,...,NREQ-1,0,... Every requester is granted within NREQ grants of asserting valid.
- rsp_ready high while rsp_valid is low is ignored.
- Reset mid-operation: the pending result is discarded and no response is emitted. Requesters must re-present their requests.
- req_ready is never high outside IDLE and is never multi-hot.

Test Plan:
- Reset release, all req_valid = 0 -> req_ready = 0, rsp_valid = 0, busy = 0 for 10 cycles.
- Requester 2 only, op = 4 (XOR), a = 8'hF0, b = 8'hAA, rsp_ready = 1 -> req_ready = 4'b0100 at T, rsp_valid at T+2 with rsp_data = 8'h5A, rsp_id = 2.
- Sweep all 8 opcodes on requester 0 with a = 8'hCC, b = 8'hAA -> rsp_data sequence 88, EE, 77, 11, 66, 99, CC, 33.
- All four requesters valid continuously, rsp_ready = 1 -> grant order 0,1,2,3,0,1; rsp_id order matches; issue interval 3 cycles.
- Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, req_ready = 0 throughout; next grant only after the rsp_ready handshake.
- Assert rst_n low in EXEC and in RESP -> outputs and pointer clear immediately; after release, the first grant goes to the lowest-index valid requester and no stale response appears.
